// File: rtl/rsa_sched.sv
// rsa_sched: round-robin scheduler that feeds one shared RSA core from N_REQ
// requester streams and routes the in-order results back through a tag FIFO.
// The tag FIFO remembers, per issued packet, which requester it came from.
module rsa_sched #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 256,
  parameter int TAG_DEPTH = 8
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [N_REQ-1:0]             s_req_tvalid,
  output logic [N_REQ-1:0]             s_req_tready,
  input  logic [N_REQ-1:0]             s_req_tlast,
  input  logic [N_REQ*DATA_W-1:0]      s_req_tdata,
  output logic                         m_core_tvalid,
  input  logic                         m_core_tready,
  output logic                         m_core_tlast,
  output logic [DATA_W-1:0]            m_core_tdata,
  input  logic                         s_core_tvalid,
  output logic                         s_core_tready,
  input  logic                         s_core_tlast,
  input  logic [DATA_W-1:0]            s_core_tdata,
  output logic [N_REQ-1:0]             m_rsp_tvalid,
  input  logic [N_REQ-1:0]             m_rsp_tready,
  output logic [N_REQ-1:0]             m_rsp_tlast,
  output logic [DATA_W-1:0]            m_rsp_tdata,
  output logic [$clog2(TAG_DEPTH):0]   inflight,
  output logic                         busy
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH) + 1;

  localparam logic [GW-1:0] LAST_RST = GW'(N_REQ - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(TAG_DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   tag_mem_q [TAG_DEPTH];
  logic [GW-1:0]   tag_mem_d [TAG_DEPTH];

  logic            push_s;
  logic            pop_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic [GW-1:0]   head_s;
  logic            rsp_ready_s;
  logic [GW:0]     pick_s;

  // Round-robin search: first valid requester after 'last', wrapping modulo N_REQ.
  // Returns {found, index}.
  function automatic logic [GW:0] rr_pick(input logic [N_REQ-1:0] vld,
                                          input logic [GW-1:0]    last);
    logic          found;
    logic [GW-1:0] idx;
    int            cand;
    found = 1'b0;
    idx   = {GW{1'b0}};
    for (int i = 1; i <= N_REQ; i++) begin
      cand = int'(last) + i;
      cand = (cand >= N_REQ) ? (cand - N_REQ) : cand;
      if (!found && vld[cand]) begin
        found = 1'b1;
        idx   = GW'(cand);
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  assign fifo_full_s  = (cnt_q == CNT_FULL);
  assign fifo_empty_s = (cnt_q == {CW{1'b0}});
  assign head_s       = tag_mem_q[rd_ptr_q];
  assign inflight     = cnt_q;
  assign busy         = (state_q == ST_XFER) || !fifo_empty_s;

  // Result routing: the FIFO head picks the destination; nothing flows while empty.
  always_comb begin
    m_rsp_tvalid = {N_REQ{1'b0}};
    m_rsp_tlast  = {N_REQ{1'b0}};
    m_rsp_tdata  = s_core_tdata;
    rsp_ready_s  = 1'b0;
    if (!fifo_empty_s) begin
      m_rsp_tvalid[head_s] = s_core_tvalid;
      m_rsp_tlast[head_s]  = s_core_tlast;
      rsp_ready_s          = m_rsp_tready[head_s];
    end else begin
      rsp_ready_s          = 1'b0;
    end
    s_core_tready = rsp_ready_s;
    pop_s         = !fifo_empty_s && s_core_tvalid && rsp_ready_s && s_core_tlast;
  end

  // Arbiter FSM: grant in IDLE (one bubble per packet), pass a whole packet in XFER.
  // A pop in the same cycle frees a slot, so a full FIFO can still accept a push then.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    push_s        = 1'b0;
    s_req_tready  = {N_REQ{1'b0}};
    m_core_tvalid = 1'b0;
    m_core_tlast  = 1'b0;
    m_core_tdata  = {DATA_W{1'b0}};
    pick_s        = rr_pick(s_req_tvalid, last_grant_q);
    case (state_q)
      ST_IDLE: begin
        if (pick_s[GW] && (!fifo_full_s || pop_s)) begin
          grant_d = pick_s[GW-1:0];
          push_s  = 1'b1;
          state_d = ST_XFER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        m_core_tvalid         = s_req_tvalid[grant_q];
        m_core_tlast          = s_req_tlast[grant_q];
        m_core_tdata          = s_req_tdata[int'(grant_q)*DATA_W +: DATA_W];
        s_req_tready[grant_q] = m_core_tready;
        if (s_req_tvalid[grant_q] && m_core_tready && s_req_tlast[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end else begin
          state_d      = ST_XFER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Tag FIFO bookkeeping: write the new grant, advance pointers, track occupancy.
  always_comb begin
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push_s) begin
      tag_mem_d[wr_ptr_q] = grant_d;
      wr_ptr_d            = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d            = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset abandons any grant and every outstanding tag.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      grant_q      <= {GW{1'b0}};
      last_grant_q <= LAST_RST;
      wr_ptr_q     <= {PW{1'b0}};
      rd_ptr_q     <= {PW{1'b0}};
      cnt_q        <= {CW{1'b0}};
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= {GW{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      tag_mem_q    <= tag_mem_d;
    end
  end

endmodule

// File: tb/tb_rsa_sched.sv
// tb_rsa_sched: directed scoreboard bench for rsa_sched.
module tb_rsa_sched;
  localparam int NQ = 4;
  localparam int DW = 32;
  localparam int TD = 8;
  localparam int CW = $clog2(TD) + 1;

  logic              aclk = 1'b0;
  logic              areset;
  logic [NQ-1:0]     s_req_tvalid, s_req_tready, s_req_tlast;
  logic [NQ*DW-1:0]  s_req_tdata;
  logic              m_core_tvalid, m_core_tready, m_core_tlast;
  logic [DW-1:0]     m_core_tdata;
  logic              s_core_tvalid, s_core_tready, s_core_tlast;
  logic [DW-1:0]     s_core_tdata;
  logic [NQ-1:0]     m_rsp_tvalid, m_rsp_tready, m_rsp_tlast;
  logic [DW-1:0]     m_rsp_tdata;
  logic [CW-1:0]     inflight;
  logic              busy;

  rsa_sched #(.N_REQ(NQ), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
    .aclk(aclk), .areset(areset),
    .s_req_tvalid(s_req_tvalid), .s_req_tready(s_req_tready),
    .s_req_tlast(s_req_tlast), .s_req_tdata(s_req_tdata),
    .m_core_tvalid(m_core_tvalid), .m_core_tready(m_core_tready),
    .m_core_tlast(m_core_tlast), .m_core_tdata(m_core_tdata),
    .s_core_tvalid(s_core_tvalid), .s_core_tready(s_core_tready),
    .s_core_tlast(s_core_tlast), .s_core_tdata(s_core_tdata),
    .m_rsp_tvalid(m_rsp_tvalid), .m_rsp_tready(m_rsp_tready),
    .m_rsp_tlast(m_rsp_tlast), .m_rsp_tdata(m_rsp_tdata),
    .inflight(inflight), .busy(busy)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int            req;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t req_pend[$];    // beats the requesters still have to send
  beat_t exp_core_q[$];  // expected beats at the core input, in order
  beat_t res_q[$];       // result beats the core model still has to return
  beat_t exp_rsp_q[$];   // expected routed results (req = destination)
  int    core_cyc[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    core_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    logic [NQ-1:0]    v, l;
    logic [NQ*DW-1:0] d;
    logic             f;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NQ; i++) begin
      f = 1'b0;
      for (int j = 0; j < req_pend.size(); j++) begin
        if (!f && req_pend[j].req == i) begin
          f = 1'b1;
          v[i] = 1'b1;
          l[i] = req_pend[j].last;
          d[i*DW +: DW] = req_pend[j].data;
        end
      end
    end
    s_req_tvalid = v;
    s_req_tlast  = l;
    s_req_tdata  = d;
    if (res_q.size() > 0) begin
      s_core_tvalid = 1'b1;
      s_core_tlast  = res_q[0].last;
      s_core_tdata  = res_q[0].data;
    end else begin
      s_core_tvalid = 1'b0;
      s_core_tlast  = 1'b0;
      s_core_tdata  = '0;
    end
  endtask

  task automatic retire_req(input int r);
    int idx;
    idx = -1;
    for (int j = 0; j < req_pend.size(); j++)
      if (idx < 0 && req_pend[j].req == r) idx = j;
    if (idx >= 0) req_pend.delete(idx);
  endtask

  // Requester/core models plus output monitors: sample at negedge, update after posedge.
  initial begin : bfm
    logic [NQ-1:0] rf;
    logic          cf;
    logic [NQ-1:0] ev;
    beat_t         e;
    drive_inputs();
    forever begin
      @(negedge aclk);
      rf = s_req_tvalid & s_req_tready;
      cf = s_core_tvalid & s_core_tready;
      if (m_core_tvalid && m_core_tready) begin
        core_cnt++;
        core_cyc.push_back(cyc);
        if (exp_core_q.size() == 0) chk("core_unexpected", exp_core_q.size(), 1);
        else begin
          e = exp_core_q.pop_front();
          chk("core_data", m_core_tdata, e.data);
          chk("core_last", m_core_tlast, e.last);
        end
      end
      if (cf) begin
        if (exp_rsp_q.size() == 0) chk("rsp_unexpected", exp_rsp_q.size(), 1);
        else begin
          e = exp_rsp_q.pop_front();
          ev = '0;
          ev[e.req] = 1'b1;
          chk("rsp_valid", m_rsp_tvalid, ev);
          chk("rsp_data", m_rsp_tdata, e.data);
          chk("rsp_last", m_rsp_tlast, e.last ? ev : '0);
        end
      end
      @(posedge aclk);
      cyc++;
      #2;
      for (int i = 0; i < NQ; i++) if (rf[i]) retire_req(i);
      if (cf && res_q.size() > 0) void'(res_q.pop_front());
      drive_inputs();
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic push_req(input int r, input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.req = r; b.data = d; b.last = l;
    req_pend.push_back(b);
  endtask

  task automatic push_core(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.req = 0; b.data = d; b.last = l;
    exp_core_q.push_back(b);
  endtask

  task automatic push_res(input int dst, input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.req = dst; b.data = d; b.last = l;
    res_q.push_back(b);
    exp_rsp_q.push_back(b);
  endtask

  task automatic wait_core(input string tag, input int target, input int budget);
    int b;
    b = budget;
    while (core_cnt < target && b > 0) begin
      step(1);
      b--;
    end
    chk(tag, core_cnt, target);
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int b;
    b = budget;
    while (exp_rsp_q.size() > 0 && b > 0) begin
      step(1);
      b--;
    end
    chk(tag, exp_rsp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Directed sequence.
  initial begin
    int base;
    int go [9];
    int pc [NQ];
    int kk [NQ];
    areset = 1'b1;
    m_core_tready = 1'b1;
    m_rsp_tready = '1;
    step(3);
    areset = 1'b0;
    @(negedge aclk);
    chk("rst_inflight", inflight, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_tvalid", m_core_tvalid, 0);
    chk("rst_req_tready", s_req_tready, 0);
    chk("rst_rsp_tvalid", m_rsp_tvalid, 0);
    chk("rst_core_tready", s_core_tready, 0);
    step(1);

    // A: four simultaneous 1-beat packets, results held off.
    base = core_cnt;
    core_cyc.delete();
    for (int i = 0; i < NQ; i++) begin
      push_req(i, 32'hA000_0000 | i, 1'b1);
      push_core(32'hA000_0000 | i, 1'b1);
    end
    @(negedge aclk);
    chk("a_idle_req_tready", s_req_tready, 0);
    chk("a_idle_core_tvalid", m_core_tvalid, 0);
    wait_core("a_issued", base + 4, 40);
    chk("a_inflight", inflight, 4);
    if (core_cyc.size() == 4)
      for (int k = 1; k < 4; k++) chk("a_gap", core_cyc[k] - core_cyc[k-1], 2);
    step(3);
    chk("a_inflight_hold", inflight, 4);
    chk("a_busy", busy, 1);
    for (int i = 0; i < NQ; i++) push_res(i, 32'hB000_0000 | i, 1'b1);
    wait_rsp("a_results", 40);
    chk("a_drained", inflight, 0);
    chk("a_idle_busy", busy, 0);

    // B: 3-beat packet from 2 is not preempted by requester 1.
    base = core_cnt;
    core_cyc.delete();
    for (int k = 0; k < 3; k++) begin
      push_req(2, 32'hC000_0000 | k, k == 2);
      push_core(32'hC000_0000 | k, k == 2);
    end
    step(1);
    push_req(1, 32'hD000_0001, 1'b1);
    push_core(32'hD000_0001, 1'b1);
    wait_core("b_issued", base + 4, 40);
    if (core_cyc.size() == 4) begin
      chk("b_contig1", core_cyc[1] - core_cyc[0], 1);
      chk("b_contig2", core_cyc[2] - core_cyc[1], 1);
      chk("b_bubble", core_cyc[3] - core_cyc[2], 2);
    end
    push_res(2, 32'hC100_0000, 1'b0);
    push_res(2, 32'hC100_0001, 1'b1);
    push_res(1, 32'hD100_0001, 1'b1);
    wait_rsp("b_results", 40);

    // C: nine packets against an 8-deep tag FIFO with results held off.
    go = '{2, 3, 0, 1, 2, 3, 0, 1, 0};
    pc = '{3, 2, 2, 2};
    kk = '{0, 0, 0, 0};
    base = core_cnt;
    for (int r = 0; r < NQ; r++)
      for (int k = 0; k < pc[r]; k++) push_req(r, 32'hE000_0000 | (r << 4) | k, 1'b1);
    for (int p = 0; p < 9; p++) begin
      push_core(32'hE000_0000 | (go[p] << 4) | kk[go[p]], 1'b1);
      kk[go[p]]++;
    end
    wait_core("c_issued8", base + 8, 60);
    step(5);
    chk("c_ninth_blocked", core_cnt, base + 8);
    chk("c_inflight_full", inflight, 8);
    chk("c_full_core_tvalid", m_core_tvalid, 0);
    chk("c_full_busy", busy, 1);
    push_res(go[0], 32'hF000_0000, 1'b1);
    @(negedge aclk);
    chk("c_pop_ready", s_core_tready, 1);
    chk("c_pre_inflight", inflight, 8);
    @(negedge aclk);
    chk("c_pushpop_inflight", inflight, 8);
    chk("c_ninth_core_tvalid", m_core_tvalid, 1);
    chk("c_ninth_req_tready", s_req_tready, 4'b0001);
    step(1);
    wait_core("c_issued9", base + 9, 20);
    for (int p = 1; p < 9; p++) push_res(go[p], 32'hF000_0000 | p, 1'b1);
    wait_rsp("c_results", 80);
    chk("c_drained", inflight, 0);

    // D: tags 3,0,3 with requester 0 stalling its result.
    base = core_cnt;
    push_req(3, 32'h3300_0001, 1'b1); push_core(32'h3300_0001, 1'b1);
    wait_core("d_issue_a", base + 1, 20);
    push_req(0, 32'h3300_0002, 1'b1); push_core(32'h3300_0002, 1'b1);
    wait_core("d_issue_b", base + 2, 20);
    push_req(3, 32'h3300_0003, 1'b1); push_core(32'h3300_0003, 1'b1);
    wait_core("d_issue_c", base + 3, 20);
    chk("d_inflight", inflight, 3);
    m_rsp_tready = 4'b1110;
    push_res(3, 32'h5300_00D3, 1'b1);
    push_res(0, 32'h5000_00A0, 1'b0);
    push_res(0, 32'h5000_00A1, 1'b1);
    push_res(3, 32'h5300_00E3, 1'b1);
    @(negedge aclk);
    chk("d_first_vld", m_rsp_tvalid, 4'b1000);
    chk("d_first_data", m_rsp_tdata, 32'h5300_00D3);
    chk("d_first_ready", s_core_tready, 1);
    @(negedge aclk);
    chk("d_stall_vld", m_rsp_tvalid, 4'b0001);
    chk("d_stall_ready", s_core_tready, 0);
    step(3);
    @(negedge aclk);
    chk("d_stall_hold", s_core_tready, 0);
    chk("d_stall_inflight", inflight, 2);
    step(1);
    m_rsp_tready = '1;
    wait_rsp("d_results", 40);
    chk("d_drained", inflight, 0);

    // E: reset during XFER with two outstanding tags.
    base = core_cnt;
    push_req(1, 32'h7100_0001, 1'b1); push_core(32'h7100_0001, 1'b1);
    wait_core("e_issue_a", base + 1, 20);
    m_core_tready = 1'b0;
    push_req(2, 32'h7200_0002, 1'b1); push_core(32'h7200_0002, 1'b1);
    step(4);
    chk("e_pre_inflight", inflight, 2);
    chk("e_pre_xfer", m_core_tvalid, 1);
    areset = 1'b1;
    req_pend.delete();
    exp_core_q.delete();
    step(1);
    areset = 1'b0;
    m_core_tready = 1'b1;
    base = core_cnt;
    push_req(3, 32'h7300_0003, 1'b1);
    push_req(0, 32'h7000_0000, 1'b1);
    push_core(32'h7000_0000, 1'b1);
    push_core(32'h7300_0003, 1'b1);
    @(negedge aclk);
    chk("e_rst_inflight", inflight, 0);
    chk("e_rst_busy", busy, 0);
    chk("e_rst_core_tvalid", m_core_tvalid, 0);
    chk("e_rst_req_tready", s_req_tready, 0);
    chk("e_rst_rsp_tvalid", m_rsp_tvalid, 0);
    chk("e_rst_core_tready", s_core_tready, 0);
    step(1);
    wait_core("e_issued", base + 2, 20);
    push_res(0, 32'h7A00_0000, 1'b1);
    push_res(3, 32'h7A00_0003, 1'b1);
    wait_rsp("e_results", 40);
    chk("e_drained", inflight, 0);
    chk("end_core_q", exp_core_q.size(), 0);
    chk("end_req_pend", req_pend.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
